// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - single-beat AXI4-Lite-style memory target with programmable latency
// Independent read and write FSMs in front of a word-addressed RAM; out-of-range accesses get SLVERR.
module axi_mem_responder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    READ_LATENCY  = 2,
  parameter int                    WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int LSB  = $clog2(DATA_WIDTH / 8);
  localparam int IDXW = $clog2(DEPTH);
  localparam int RCW  = $clog2(READ_LATENCY) + 1;
  localparam int WCW  = $clog2(WRITE_LATENCY) + 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH * (DATA_WIDTH / 8));
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_RST, R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [2:0] {W_RST, W_IDLE, W_COMMIT, W_WAIT, W_RESP} w_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  r_state_e              r_state_q, r_state_d;
  logic [RCW-1:0]        r_cnt_q, r_cnt_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, ar_off;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_in_range;
  logic [IDXW-1:0]       ar_idx;

  w_state_e              w_state_q, w_state_d;
  logic [WCW-1:0]        w_cnt_q, w_cnt_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, aw_off;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                  aw_in_range, mem_we;
  logic [IDXW-1:0]       aw_idx;

  // Subtracting the base first makes below-base addresses wrap to huge offsets, so one compare covers both ends.
  assign ar_off      = ar_addr_q - BASE_ADDR;
  assign ar_in_range = {1'b0, ar_off} < SPAN;
  assign ar_idx      = ar_off[LSB +: IDXW];
  assign aw_off      = aw_addr_q - BASE_ADDR;
  assign aw_in_range = {1'b0, aw_off} < SPAN;
  assign aw_idx      = aw_off[LSB +: IDXW];

  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign bresp = bresp_q;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    ar_addr_d = ar_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state_q)
      R_RST: r_state_d = R_IDLE;
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          ar_addr_d = araddr;
          r_cnt_d   = RCW'(READ_LATENCY - 1);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          rdata_d   = ar_in_range ? mem_q[ar_idx] : '0;
          rresp_d   = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end else begin
          r_cnt_d = r_cnt_q - 1'b1;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state_q <= R_RST;
      r_cnt_q   <= '0;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      ar_addr_q <= ar_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    bresp_d   = bresp_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_RST: w_state_d = W_IDLE;
      W_IDLE: begin
        awready = !aw_held_q;
        wready  = !w_held_q;
        if (awready && awvalid) begin
          aw_held_d = 1'b1;
          aw_addr_d = awaddr;
        end
        if (wready && wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
        end
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        mem_we    = aw_in_range;
        bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        w_cnt_d   = WCW'(WRITE_LATENCY - 1);
        w_state_d = W_WAIT;
      end
      W_WAIT: begin
        if (w_cnt_q == '0) w_state_d = W_RESP;
        else               w_cnt_d   = w_cnt_q - 1'b1;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_state_q <= W_RST;
      w_cnt_q   <= '0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      bresp_q   <= bresp_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
    end
  end

  // RAM contents survive reset; a commit coinciding with a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem_q[aw_idx] <= wdata_q;
  end

endmodule
